aes_cipher_iter: RTL and testbench

//  Iterative AES-128 encryption datapath. Sits directly downstream of the key expansion block.

---
 rtl/aes_cipher_iter_pkg.sv | 60 ++++++
 rtl/aes_cipher_iter_round.sv | 35 +++
 rtl/aes_cipher_iter.sv | 90 +++++++++
 tb/tb_aes_cipher_iter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_cipher_iter_pkg.sv
// Shared AES-128 constants, FSM encoding and byte-level helpers for the
// iterative cipher datapath.
package aes_cipher_iter_pkg;

  localparam int          NR         = 10;
  localparam int          RK_IDXW    = 4;
  localparam logic [3:0]  LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Row n holds S-box outputs for inputs 8'hn0..8'hnf, leftmost byte first.
  localparam logic [0:15][127:0] SBOX_ROWS = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    logic [7:0]   res;
    row = SBOX_ROWS[b[7:4]];
    res = '0;
    for (int j = 0; j < 16; j++) begin
      if (b[3:0] == j[3:0]) res = row[127-8*j -: 8];
    end
    return res;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One state column, row 0 in the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_cipher_iter_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped
// on the final round) and AddRoundKey. Byte i lives at [127-8i -: 8].
module aes_cipher_iter_round
  import aes_cipher_iter_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] out
);

  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;

  always_comb begin
    sb  = '0;
    sr  = '0;
    mc  = '0;
    for (int i = 0; i < 16; i++) begin
      sb[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
    end
    // Column-major layout: row r of column c takes row r of column (c+r)%4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end
    out = (last ? sr : mc) ^ rk;
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryptor: one round per cycle, round keys fetched by
// index from the key-expansion table, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for plaintext; initial AddRoundKey on accept
// RUN   | applying rounds 1..10, rk_idx = round
// DONE  | ciphertext held on out_data until out_ready
module aes_cipher_iter
  import aes_cipher_iter_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] st_q, st_d;
  logic [127:0] round_out;
  logic         last_round;

  assign last_round = (round_q == LAST_ROUND);

  aes_cipher_iter_round u_round (
    .st   (st_q),
    .rk   (rk),
    .last (last_round),
    .out  (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      st_q    <= st_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    st_d    = st_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          st_d    = in_data ^ rk;
          round_d = 4'd1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        st_d = round_out;
        // Exit on an explicit compare so the counter never runs past 10.
        if (last_round) begin
          round_d = '0;
          state_d = ST_DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        round_d = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = rst_n && key_valid && (state_q == ST_IDLE);
    rk_idx    = (state_q == ST_RUN) ? round_q : 4'd0;
    out_valid = (state_q == ST_DONE);
    out_data  = out_valid ? st_q : '0;
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Scoreboarded bench for aes_cipher_iter: a byte-array AES model with an
// arithmetic S-box predicts each ciphertext; a negedge monitor compares.
module tb_aes_cipher_iter;

  typedef logic [127:0] rk_t [0:10];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;

  rk_t          rk_tab;
  logic [127:0] exp_q [$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;
  int           acc_cyc  = -1;
  int           hs_cyc   = -1;
  logic         ov_prev  = 1'b0;
  bit           rand_rdy = 1'b0;

  aes_cipher_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic rk_t expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rk_t         r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])}
            ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) r[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return r;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    rk_t          r;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    r = expand(key);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ r[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_ref(s[i]);
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ r[rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_prev && acc_cyc >= 0)
        check("latency", 128'(cyc - acc_cyc), 128'd11);
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_output", 128'd1, 128'd0);
        else check("ciphertext", out_data, exp_q.pop_front());
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] key, input logic [127:0] pt, input bit chk_rk);
    @(posedge clk);
    #1;
    rk_tab   = expand(key);
    in_data  = pt;
    in_valid = 1'b1;
    exp_q.push_back(aes_ref(key, pt));
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) begin
      check("accept_timeout", 128'd0, 128'd1);
      in_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    acc_cyc = cyc;
    if (chk_rk) check("rk_idx_0", 128'(rk_idx), 128'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (chk_rk) begin
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        check($sformatf("rk_idx_%0d", k), 128'(rk_idx), 128'(k));
      end
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready) return;
    end
    check("idle_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_out();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    check("out_valid_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    int           bad;
    logic [127:0] held;
    logic [127:0] rkey, rpt;

    for (int i = 0; i < 11; i++) rk_tab[i] = '0;
    key_valid = 1'b1;
    #2;
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_rk_idx", 128'(rk_idx), 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready), 128'd1);

    // FIPS-197 C.1
    out_ready = 1'b1;
    send(K1, P1, 1'b0);
    wait_out();
    check("fips_c1", out_data, C1);
    wait_idle();

    // FIPS-197 App.B with per-cycle round-key index
    send(K2, P2, 1'b1);
    wait_out();
    check("fips_b", out_data, C2);
    wait_idle();

    // Backpressure
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(K1, P1, 1'b0);
    wait_out();
    held = out_data;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("bp_stable", 128'(bad), 128'd0);
    check("bp_data", held, C1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_out_valid", 128'(out_valid), 128'd0);
    check("bp_release_in_ready", 128'(in_ready), 128'd1);

    // Back-to-back with out_ready tied high
    send(K1, P1, 1'b0);
    send(K1, P1, 1'b0);
    check("b2b_gap", 128'(acc_cyc - hs_cyc), 128'd1);
    wait_idle();

    // key_valid gating
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    rk_tab    = expand(K2);
    in_data   = P2;
    in_valid  = 1'b1;
    exp_q.push_back(aes_ref(K2, P2));
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || rk_idx !== 4'd0) bad++;
    end
    check("kv_block", 128'(bad), 128'd0);
    @(posedge clk);
    #1 key_valid = 1'b1;
    @(negedge clk);
    check("kv_accept", 128'(in_ready), 128'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();

    // Reset in the middle of round 5
    send(K1, P1, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 128'(out_valid), 128'd0);
    check("rst_mid_in_ready", 128'(in_ready), 128'd0);
    exp_q.delete();
    acc_cyc = -1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_idle", 128'({in_ready, out_valid, rk_idx}), 128'({1'b1, 1'b0, 4'd0}));
    send(K1, P1, 1'b0);
    wait_out();
    check("fips_c1_after_rst", out_data, C1);
    wait_idle();

    // Random keys/plaintexts with random output backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 16; n++) begin
      wait_idle();
      rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
      rpt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(rkey, rpt, 1'b0);
    end
    wait_idle();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
